// File: rtl/multi_lfo_if.sv
// multi_lfo_if: valid/ready sample stream from the LFO engine to the DAC side.
//   out_valid  master->slave  sample available
//   out_ready  slave->master  consumer accepts the sample this cycle
//   out_chan   master->slave  channel index of out_data
//   out_data   master->slave  unsigned sample
interface multi_lfo_if #(
  parameter int DATA_W = 12,
  parameter int CHAN_W = 1
);
  logic              out_valid;
  logic              out_ready;
  logic [CHAN_W-1:0] out_chan;
  logic [DATA_W-1:0] out_data;

  modport master (
    output out_valid,
    output out_chan,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_chan,
    input  out_data,
    output out_ready
  );
endinterface

// File: rtl/multi_lfo_core.sv
// multi_lfo_core: N-channel LFO engine.
// A common sample tick advances every channel's phase accumulator. A scan FSM
// then computes each channel's depth-scaled sample in turn and presents it on
// a valid/ready stream.
//   clk       system clock
//   rst       synchronous, active-high reset
//   sync      one-cycle pulse, zeroes all phases (wins over a same-cycle tick)
//   en        per-channel enable (disabled channel: phase 0, output MID)
//   shape     per-channel shape index, channel c at [3c+2:3c]
//   depth     per-channel depth index 0..7, channel c at [3c+2:3c]
//   freq      per-channel frequency index 0..255, channel c at [8c+7:8c]
//   out_if    sample stream (out_valid/out_ready/out_chan/out_data)
//   rate_led  registered phase MSB per channel
//   overrun   sticky, set when a tick arrives while a scan is in progress
module multi_lfo_core #(
  parameter int CHANNELS   = 2,
  parameter int DATA_W     = 12,
  parameter int PHASE_W    = 24,
  parameter int INC_UNIT   = 1,
  parameter int SAMPLE_DIV = 1000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sync,
  input  logic [CHANNELS-1:0]     en,
  input  logic [3*CHANNELS-1:0]   shape,
  input  logic [3*CHANNELS-1:0]   depth,
  input  logic [8*CHANNELS-1:0]   freq,
  multi_lfo_if.master             out_if,
  output logic [CHANNELS-1:0]     rate_led,
  output logic                    overrun
);

  localparam int CHAN_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CNT_W  = $clog2(SAMPLE_DIV);
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_PRESENT
  } state_t;

  // ---------------------------------------------------------------------
  // Sample tick
  // ---------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_reg;
  logic             tick;

  assign tick = (cnt_reg == CNT_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Free-running LFSR (Fibonacci, taps 16,14,13,11), source for random shape
  // ---------------------------------------------------------------------
  logic [15:0] lfsr_reg;
  logic        lfsr_fb;

  assign lfsr_fb = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= LFSR_SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_fb};
    end
  end

  // ---------------------------------------------------------------------
  // Phase accumulators, random sample-and-hold, rate LEDs
  // ---------------------------------------------------------------------
  logic [PHASE_W-1:0] phase_reg [CHANNELS];
  logic [DATA_W-1:0]  rnd_reg   [CHANNELS];
  logic [CHANNELS-1:0] rate_led_reg;
  // One extra bit on the sum so bit PHASE_W is the wrap carry.
  logic [PHASE_W:0]   inc_w     [CHANNELS];
  logic [PHASE_W:0]   sum_w     [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    assign inc_w[gi] = (PHASE_W+1)'((freq[8*gi +: 8] + 9'd1) * INC_UNIT);
    assign sum_w[gi] = {1'b0, phase_reg[gi]} + inc_w[gi];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        phase_reg[c] <= '0;
        rnd_reg[c]   <= '0;
      end
      rate_led_reg <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (sync) begin
          phase_reg[c] <= '0;
        end else if (tick) begin
          if (en[c]) begin
            phase_reg[c] <= sum_w[c][PHASE_W-1:0];
            if (sum_w[c][PHASE_W]) begin
              rnd_reg[c] <= lfsr_reg[15 -: DATA_W];
            end
          end else begin
            phase_reg[c] <= '0;
          end
        end
        rate_led_reg[c] <= phase_reg[c][PHASE_W-1];
      end
    end
  end

  assign rate_led = rate_led_reg;

  // ---------------------------------------------------------------------
  // Sample computation for the channel currently being scanned
  // ---------------------------------------------------------------------
  state_t              state_reg;
  logic [CHAN_W-1:0]   idx_reg;
  logic                out_valid_reg;
  logic [CHAN_W-1:0]   out_chan_reg;
  logic [DATA_W-1:0]   out_data_reg;
  logic                overrun_reg;

  logic [2:0]          shape_sel;
  logic [2:0]          depth_sel;
  logic                en_sel;
  logic [PHASE_W-1:0]  phase_sel;
  logic [DATA_W-1:0]   rnd_sel;
  logic [DATA_W-1:0]   p_w;
  logic [DATA_W-1:0]   t_w;
  logic                m_w;
  logic [DATA_W-1:0]   wave_w;
  logic signed [DATA_W+3:0] d_s;
  logic signed [DATA_W+3:0] k_s;
  logic signed [DATA_W+3:0] prod_s;
  logic signed [DATA_W+3:0] scaled_s;
  logic [DATA_W-1:0]   sample_w;

  // Compare-based mux rather than array indexing so idx never addresses
  // beyond CHANNELS when CHANNELS is not a power of two.
  always_comb begin
    shape_sel = '0;
    depth_sel = '0;
    en_sel    = 1'b0;
    phase_sel = '0;
    rnd_sel   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (idx_reg == CHAN_W'(c)) begin
        shape_sel = shape[3*c +: 3];
        depth_sel = depth[3*c +: 3];
        en_sel    = en[c];
        phase_sel = phase_reg[c];
        rnd_sel   = rnd_reg[c];
      end
    end
  end

  assign p_w = phase_sel[PHASE_W-1 -: DATA_W];
  assign t_w = phase_sel[PHASE_W-2 -: DATA_W];
  assign m_w = phase_sel[PHASE_W-1];

  always_comb begin
    wave_w = MID;
    case (shape_sel)
      3'd0:    wave_w = m_w ? ~t_w : t_w;
      3'd1:    wave_w = p_w;
      3'd2:    wave_w = ~p_w;
      3'd3:    wave_w = m_w ? {DATA_W{1'b1}} : {DATA_W{1'b0}};
      3'd4:    wave_w = rnd_sel;
      default: wave_w = MID;
    endcase
  end

  // Depth scaling around MID: out = MID + ((wave-MID)*(depth+1)) >>> 3.
  // |wave-MID| <= 2^(DATA_W-1), times 8 still fits DATA_W+4 signed bits,
  // and the result stays within 0..2^DATA_W-1, so a DATA_W-bit add is exact.
  always_comb begin
    d_s      = $signed({4'b0000, wave_w}) - $signed({4'b0000, MID});
    k_s      = $signed((DATA_W+4)'(depth_sel) + (DATA_W+4)'(1));
    prod_s   = d_s * k_s;
    scaled_s = prod_s >>> 3;
    sample_w = en_sel ? (MID + scaled_s[DATA_W-1:0]) : MID;
  end

  // ---------------------------------------------------------------------
  // Scan FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      idx_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_chan_reg  <= '0;
      out_data_reg  <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      // A tick that finds a scan still running is dropped and flagged.
      if (tick && (state_reg != ST_IDLE)) begin
        overrun_reg <= 1'b1;
      end
      case (state_reg)
        ST_IDLE: begin
          if (tick) begin
            idx_reg   <= '0;
            state_reg <= ST_CALC;
          end
        end
        ST_CALC: begin
          out_data_reg  <= sample_w;
          out_chan_reg  <= idx_reg;
          out_valid_reg <= 1'b1;
          state_reg     <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (out_if.out_ready) begin
            out_valid_reg <= 1'b0;
            if (idx_reg == CHAN_W'(CHANNELS - 1)) begin
              state_reg <= ST_IDLE;
            end else begin
              idx_reg   <= idx_reg + CHAN_W'(1);
              state_reg <= ST_CALC;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_if.out_valid = out_valid_reg;
  assign out_if.out_chan  = out_chan_reg;
  assign out_if.out_data  = out_data_reg;
  assign overrun          = overrun_reg;

endmodule

// File: tb/tb_multi_lfo_core.sv
// tb_multi_lfo_core: directed vector table plus hand-written sequences for
// multi_lfo_core with CHANNELS=2, DATA_W=12, PHASE_W=16, SAMPLE_DIV=16.
module tb_multi_lfo_core;

  localparam int CHANNELS   = 2;
  localparam int DATA_W     = 12;
  localparam int PHASE_W    = 16;
  localparam int INC_UNIT   = 1;
  localparam int SAMPLE_DIV = 16;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  sync;
  logic [CHANNELS-1:0]   en;
  logic [3*CHANNELS-1:0] shape;
  logic [3*CHANNELS-1:0] depth;
  logic [8*CHANNELS-1:0] freq;
  logic [CHANNELS-1:0]   rate_led;
  logic                  overrun;

  multi_lfo_if #(.DATA_W(DATA_W), .CHAN_W(1)) bus ();

  multi_lfo_core #(
    .CHANNELS  (CHANNELS),
    .DATA_W    (DATA_W),
    .PHASE_W   (PHASE_W),
    .INC_UNIT  (INC_UNIT),
    .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .sync    (sync),
    .en      (en),
    .shape   (shape),
    .depth   (depth),
    .freq    (freq),
    .out_if  (bus),
    .rate_led(rate_led),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  // Reference LFSR with a two-cycle history, so the value present in a tick
  // cycle T can be read when channel 0 is valid at T+2.
  logic [15:0] lfsr_m, lfsr_d1, lfsr_d2;
  always @(posedge clk) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    lfsr_d1 <= lfsr_m;
    lfsr_d2 <= lfsr_d1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end else begin
      $display("ok   %s value=%0d", name, act);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_chan(input int c, input int sh, input int dp, input int fr, input int e);
    shape[3*c +: 3] = 3'(sh);
    depth[3*c +: 3] = 3'(dp);
    freq[8*c +: 8]  = 8'(fr);
    en[c]           = e[0];
  endtask

  // Waits for the next handshake cycle (sampled on the falling edge).
  task automatic get_sample(output int ch, output int data);
    bit got;
    got  = 1'b0;
    ch   = -1;
    data = -1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin
        got  = 1'b1;
        ch   = int'(bus.out_chan);
        data = int'(bus.out_data);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL sample_timeout actual=none required=handshake");
    end
  endtask

  typedef struct {
    int shape;
    int depth;
    int freq;
    int en;
    int n;      // number of ticks before the checked ch0 sample
    int exp;
  } vec_t;

  vec_t vecs[15];

  initial begin
    int ch, d, c0, d0, err, first, rnd_exp;

    vecs[0]  = '{1, 7, 255, 1,   1,   16};  // saw up, phase 256
    vecs[1]  = '{1, 7, 255, 1,   3,   48};  // saw up, phase 768
    vecs[2]  = '{2, 7, 255, 1,   1, 4079};  // saw down
    vecs[3]  = '{0, 7, 255, 1,   1,   32};  // triangle rising half
    vecs[4]  = '{0, 7, 255, 1, 130, 4031};  // triangle falling half, phase 0x8200
    vecs[5]  = '{3, 7, 255, 1,   1,    0};  // square low
    vecs[6]  = '{3, 7, 255, 1, 128, 4095};  // square high, phase 0x8000
    vecs[7]  = '{5, 3,  10, 1,   1, 2048};  // reserved shape -> MID
    vecs[8]  = '{7, 7, 255, 1,   2, 2048};  // reserved shape -> MID
    vecs[9]  = '{1, 7, 255, 0,   2, 2048};  // disabled -> MID
    vecs[10] = '{1, 0, 255, 1,   1, 1794};  // wave 16, depth 0
    vecs[11] = '{1, 3, 255, 1,   1, 1032};  // wave 16, depth 3
    vecs[12] = '{2, 5, 127, 1,   1, 3577};  // wave 4087, depth 5
    vecs[13] = '{2, 0, 255, 1, 256, 2303};  // phase wrapped to 0, wave 4095
    vecs[14] = '{1, 0, 255, 1, 256, 1792};  // phase wrapped to 0, wave 0

    rst = 1'b1;
    sync = 1'b0;
    en = '0;
    shape = '0;
    depth = '0;
    freq = '0;
    bus.out_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_chan", int'(bus.out_chan), 0);
    check("rst_data", int'(bus.out_data), 0);
    check("rst_rate_led", int'(rate_led), 0);
    check("rst_overrun", int'(overrun), 0);

    // Vector table
    for (int v = 0; v < 15; v++) begin
      do_reset();
      set_chan(0, vecs[v].shape, vecs[v].depth, vecs[v].freq, vecs[v].en);
      set_chan(1, 7, 7, 0, 1);
      c0 = -1;
      d0 = -1;
      for (int k = 0; k < vecs[v].n; k++) begin
        get_sample(c0, d0);
        get_sample(ch, d);
      end
      check($sformatf("vec%0d_chan", v), c0, 0);
      check($sformatf("vec%0d_data", v), d0, vecs[v].exp);
    end

    // Saw phase arithmetic and rate LED
    do_reset();
    set_chan(0, 1, 7, 255, 1);
    set_chan(1, 7, 7, 0, 1);
    err = 0;
    for (int k = 1; k <= 260; k++) begin
      get_sample(c0, d0);
      if (d0 != (16 * k) % 4096) err++;
      if (k == 127 || k == 128 || k == 255 || k == 256)
        check($sformatf("rate_led_k%0d", k), int'(rate_led[0]), (k / 128) % 2);
      get_sample(ch, d);
    end
    check("saw_sequence_errors", err, 0);

    // Backpressure and overrun
    do_reset();
    set_chan(0, 1, 7, 255, 1);
    set_chan(1, 1, 7, 255, 1);
    bus.out_ready = 1'b0;
    first = 0;
    for (int i = 0; i < 100 && first == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) first = 1;
    end
    check("bp_valid_seen", first, 1);
    c0 = int'(bus.out_chan);
    d0 = int'(bus.out_data);
    check("bp_chan", c0, 0);
    check("bp_data", d0, 16);
    err = 0;
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      if (!bus.out_valid || int'(bus.out_chan) != c0 || int'(bus.out_data) != d0) err++;
    end
    check("bp_hold_stable_errors", err, 0);
    check("bp_overrun_set", int'(overrun), 1);
    bus.out_ready = 1'b1;
    get_sample(ch, d);
    check("bp_ch1_chan", ch, 1);
    check("bp_ch1_three_incs", d, 48);
    get_sample(ch, d);
    check("bp_next_ch0", d, 64);
    get_sample(ch, d);
    get_sample(ch, d);
    get_sample(ch, d);
    check("bp_overrun_sticky", int'(overrun), 1);

    // Enable and sync
    do_reset();
    set_chan(0, 1, 7, 255, 1);
    set_chan(1, 1, 7, 255, 0);
    for (int k = 1; k <= 3; k++) begin
      get_sample(ch, d);
      get_sample(ch, d);
      check($sformatf("en0_ch1_mid_k%0d", k), d, 2048);
    end
    en[1] = 1'b1;
    get_sample(ch, d);
    check("en_ch0_k4", d, 64);
    get_sample(ch, d);
    check("en_ch1_from_zero", d, 16);
    // Now at ch1-valid cycle T+4; next tick cycle is T+16.
    repeat (12) @(negedge clk);
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
    get_sample(ch, d);
    check("sync_ch0_zero", d, 0);
    get_sample(ch, d);
    check("sync_ch1_zero", d, 0);

    // Random shape: ch0 wraps on tick 256 only
    do_reset();
    set_chan(0, 4, 7, 255, 1);
    set_chan(1, 7, 7, 0, 1);
    err = 0;
    rnd_exp = -1;
    for (int k = 1; k <= 257; k++) begin
      get_sample(ch, d);
      if (k < 256 && d != 0) err++;
      if (k == 256) begin
        rnd_exp = int'(lfsr_d2[15:4]);
        check("rnd_at_wrap", d, rnd_exp);
      end
      if (k == 257) check("rnd_held", d, rnd_exp);
      get_sample(ch, d);
    end
    check("rnd_before_wrap_errors", err, 0);

    // Reset mid-scan
    do_reset();
    set_chan(0, 1, 7, 255, 1);
    set_chan(1, 1, 7, 255, 1);
    bus.out_ready = 1'b0;
    first = 0;
    for (int i = 0; i < 100 && first == 0; i++) begin
      @(negedge clk);
      if (bus.out_valid) first = 1;
    end
    repeat (16) @(negedge clk);
    check("mid_pre_overrun", int'(overrun), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.out_ready = 1'b1;
    check("mid_rst_valid", int'(bus.out_valid), 0);
    check("mid_rst_chan", int'(bus.out_chan), 0);
    check("mid_rst_data", int'(bus.out_data), 0);
    check("mid_rst_overrun", int'(overrun), 0);
    check("mid_rst_rate_led", int'(rate_led), 0);
    first = -1;
    c0 = -1;
    d0 = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        first = k;
        c0 = int'(bus.out_chan);
        d0 = int'(bus.out_data);
      end
    end
    check("mid_first_valid_cycle", first, 17);
    check("mid_first_chan", c0, 0);
    check("mid_first_data", d0, 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_lfo_core.md
# multi_lfo_core

Parametrised N-channel LFO engine that replaces the single fixed LFO path in the top level. Each channel has its own phase accumulator, wave shape, depth and frequency index. A common sample tick advances every channel's phase. A scan FSM then computes each channel's depth-scaled sample in turn and hands it to the DAC interface over a valid/ready stream. A random shape (LFSR sample-and-hold), a per-channel enable, a phase-sync input and an overrun flag are added.

## Interface
- CHANNELS, 2, number of LFO channels (1..8)
- DATA_W, 12, output sample width (4..16)
- PHASE_W, 24, phase accumulator width (≥ DATA_W+1)
- INC_UNIT, 1, phase increment per frequency step
- SAMPLE_DIV, 1000, clocks per sample tick (≥ 2*CHANNELS+2)
- clk  in  1  system clock (CLOCK_50 at top)
- rst  in  1  synchronous, active-high reset
- sync  in  1  one-cycle pulse; zeroes all phases
- en  in  CHANNELS  per-channel enable
- shape  in  3*CHANNELS  per-channel shape index, channel c at [3c+2:3c]
- depth  in  3*CHANNELS  per-channel depth index 0..7
- freq  in  8*CHANNELS  per-channel frequency index 0..255
- out_valid  out  1  sample available
- out_ready  in  1  consumer accepts sample
- out_chan  out  $clog2(CHANNELS) (min 1)  channel of out_data
- out_data  out  DATA_W  unsigned sample
- rate_led  out  CHANNELS  phase MSB per channel (rate indicator)
- overrun  out  1  sticky: tick arrived while scan busy

## Operation
- Tick counter runs 0..SAMPLE_DIV-1 and wraps. tick=1 when count==SAMPLE_DIV-1.
- Phase update on tick, for channel c:
  - en[c]=1: phase[c] += (freq[c]+1)*INC_UNIT, modulo 2^PHASE_W.
  - en[c]=0: phase[c] is held at 0.
- wrap[c] = carry out of that addition.
- sync=1 zeroes every phase, with priority over a same-cycle tick.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1, advances every clock.
- rnd[c] latches LFSR[15 -: DATA_W] on each tick where wrap[c]=1.
- Waveform, with p = phase[PHASE_W-1 -: DATA_W], t = phase[PHASE_W-2 -: DATA_W], m = phase MSB:
  - shape 0 triangle: m ? ~t : t
  - shape 1 saw up: p
  - shape 2 saw down: ~p
  - shape 3 square: m ? all-ones : 0
  - shape 4 random: rnd[c]
  - shapes 5–7: MID = 2^(DATA_W-1)
- Depth scaling:
  - d = wave − MID, signed DATA_W+1 bits.
  - s = (d*(depth+1)) >>> 3, arithmetic, computed in DATA_W+4 bits.
  - out = MID + s. Cannot overflow.
  - depth 7 returns the wave exactly.
- en[c]=0 forces out = MID.
- Scan FSM states:
  - IDLE: on tick go to CALC with idx=0. If a tick arrives in any other state, no new scan starts and overrun is set to 1.
  - CALC: register the sample for idx using the current shape, depth and en. Go to PRESENT.
  - PRESENT: out_valid=1, with out_chan and out_data held stable. On out_valid & out_ready: if idx==CHANNELS-1 go to IDLE, else idx+1 and go to CALC.
- Phase keeps advancing on every tick regardless of the scan state, so frequency accuracy is independent of backpressure.
- rate_led[c] = phase[c] MSB, registered.

## Timing
- Reset (any cycle, including mid-scan), outputs take these values the next cycle:
  - out_valid=0, out_chan=0, out_data=0
  - all phases=0, rnd=0, rate_led=0, overrun=0
  - tick count=0, LFSR=seed, FSM=IDLE
- Tick in cycle T (out_ready held 1):
  - Updated phase visible at T+1.
  - CALC ch0 at T+1.
  - out_valid for ch0 at T+2.
  - Channel k valid at T+2+2k.
  - FSM returns to IDLE at T+2*CHANNELS+1.
- out_valid never drops without a handshake, and out_data/out_chan do not change while it is high.
- freq is sampled on the tick. shape, depth and en are sampled in CALC.
- No combinational path from out_ready to out_valid.

## Test plan
- Saw phase arithmetic:
  - Setup: CHANNELS=2, DATA_W=12, PHASE_W=16, INC_UNIT=1, SAMPLE_DIV=16, out_ready=1, ch0 shape 1, depth 7, freq 255.
  - Required: the k-th ch0 sample is 16k mod 4096.
  - Required: rate_led[0] toggles every 128 ticks.
- Depth scaling:
  - Setup: saw down with phase 0, so wave=4095, at depth 0.
  - Required: out_data=2303.
  - Setup: saw up with phase 0, so wave=0, at depth 0.
  - Required: out_data=1792.
  - Required: square at depth 7 gives 0/4095.
- Backpressure and overrun:
  - Stimulus: hold out_ready=0 for 40 clocks.
  - Required: out_valid stays 1 with out_chan and out_data stable.
  - Required: overrun=1 after the next tick and stays 1 until rst.
  - Required: phases have advanced by 3 increments.
- Enable and sync:
  - Stimulus: en[1]=0.
  - Required: ch1 samples are 2048 and phase stays 0.
  - Stimulus: sync and tick in the same cycle.
  - Required: all phases are 0 afterwards.
- Random shape:
  - Setup: shape 4.
  - Required: the sample changes only on ticks following a phase wrap, and equals the LFSR top 12 bits captured at that wrap.
- Reset mid-scan:
  - Stimulus: assert rst while out_valid=1.
  - Required: out_valid=0 next cycle and all reset values hold.
  - Required: the first tick after rst produces ch0 at T+2.
